// File: rtl/frame_buffer_writer_pkg.sv
// Shared video constants: default raster geometry and the frame writer
// state encoding, also used by the display read path.
package frame_buffer_writer_pkg;

  localparam int H_RES_DEFAULT  = 640;
  localparam int V_RES_DEFAULT  = 480;
  localparam int ADDR_W_DEFAULT = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } fbw_state_t;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_buffer_writer_pixel_addr_counter.sv
// Raster position counter: tracks column x, line y and the linear byte
// address y*H_RES+x by plain incrementing, so no multiplier is needed.
module pixel_addr_counter
  import frame_buffer_writer_pkg::*;
#(
  parameter int H_RES  = H_RES_DEFAULT,
  parameter int V_RES  = V_RES_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int X_W    = cnt_width(H_RES),
  parameter int Y_W    = cnt_width(V_RES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

  logic [X_W-1:0]    x_reg, x_next;
  logic [Y_W-1:0]    y_reg, y_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;

  // Next position: clear wins, otherwise step one pixel with line wrap.
  always_comb begin
    x_next    = x_reg;
    y_next    = y_reg;
    addr_next = addr_reg;
    if (clear) begin
      x_next    = '0;
      y_next    = '0;
      addr_next = '0;
    end else if (advance) begin
      addr_next = addr_reg + ADDR_W'(1);
      if (x_reg == X_MAX) begin
        x_next = '0;
        y_next = (y_reg == Y_MAX) ? '0 : y_reg + Y_W'(1);
      end else begin
        x_next = x_reg + X_W'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg    <= '0;
      y_reg    <= '0;
      addr_reg <= '0;
    end else begin
      x_reg    <= x_next;
      y_reg    <= y_next;
      addr_reg <= addr_next;
    end
  end

  assign x    = x_reg;
  assign y    = y_reg;
  assign addr = addr_reg;
  assign last = (x_reg == X_MAX) && (y_reg == Y_MAX);

endmodule

// File: rtl/frame_buffer_writer.sv
// Captures one frame of grayscale pixels into frame memory on request,
// yielding to the display reader whenever it holds the memory.
module frame_buffer_writer
  import frame_buffer_writer_pkg::*;
#(
  parameter int H_RES  = H_RES_DEFAULT,
  parameter int V_RES  = V_RES_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  input  logic              pix_eol,
  input  logic              mem_busy,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              busy,
  output logic              frame_done,
  output logic              line_err
);

  localparam int X_W = cnt_width(H_RES);
  localparam int Y_W = cnt_width(V_RES);
  localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);

  fbw_state_t state_reg, state_next;

  logic              accept;
  logic              cnt_clear;
  logic [X_W-1:0]    cnt_x;
  logic [Y_W-1:0]    cnt_y_unused;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_last;
  logic              eol_mismatch;

  logic [ADDR_W-1:0] mem_addr_reg;
  logic [7:0]        mem_data_reg;
  logic              mem_we_reg;
  logic              line_err_reg;

  // Counters sit at zero throughout IDLE so a capture always begins at 0,0.
  pixel_addr_counter #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .advance (accept),
    .x       (cnt_x),
    .y       (cnt_y_unused),
    .addr    (cnt_addr),
    .last    (cnt_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_WRITE;
      ST_WRITE: if (accept && cnt_last) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Decoded outputs and handshake from the current state.
  always_comb begin
    pix_ready  = (state_reg == ST_WRITE) && !mem_busy;
    busy       = (state_reg != ST_IDLE);
    frame_done = (state_reg == ST_DONE);
    cnt_clear  = (state_reg == ST_IDLE);
    accept     = pix_valid && pix_ready;
  end

  // End-of-line marker must agree with the column the counter is on.
  assign eol_mismatch = pix_eol != (cnt_x == X_MAX);

  // Memory write port: one strobe the cycle after each accepted pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_reg <= '0;
      mem_data_reg <= '0;
      mem_we_reg   <= 1'b0;
    end else begin
      mem_we_reg <= accept;
      if (accept) begin
        mem_addr_reg <= cnt_addr;
        mem_data_reg <= pix_data;
      end
    end
  end

  // Sticky line-length error, cleared when a new capture starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_err_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && start) begin
      line_err_reg <= 1'b0;
    end else if (accept && eol_mismatch) begin
      line_err_reg <= 1'b1;
    end
  end

  assign mem_addr = mem_addr_reg;
  assign mem_data = mem_data_reg;
  assign mem_we   = mem_we_reg;
  assign line_err = line_err_reg;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer: a 4x2 instance for the detailed
// scenarios and a 40x30 instance for a complete-frame count.
module tb_frame_buffer_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance (4x2)
  logic       reset, start, pix_valid, pix_eol, mem_busy;
  logic [7:0] pix_data;
  logic       pix_ready, mem_we, busy, frame_done, line_err;
  logic [2:0] mem_addr;
  logic [7:0] mem_data;

  // Larger instance (40x30)
  logic        reset_b, start_b, pix_valid_b, pix_eol_b, mem_busy_b;
  logic [7:0]  pix_data_b;
  logic        pix_ready_b, mem_we_b, busy_b, frame_done_b, line_err_b;
  logic [10:0] mem_addr_b;
  logic [7:0]  mem_data_b;

  frame_buffer_writer #(.H_RES(4), .V_RES(2), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_eol(pix_eol), .mem_busy(mem_busy),
    .pix_ready(pix_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .busy(busy), .frame_done(frame_done), .line_err(line_err)
  );

  frame_buffer_writer #(.H_RES(40), .V_RES(30), .ADDR_W(11)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .pix_valid(pix_valid_b),
    .pix_data(pix_data_b), .pix_eol(pix_eol_b), .mem_busy(mem_busy_b),
    .pix_ready(pix_ready_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
    .mem_we(mem_we_b), .busy(busy_b), .frame_done(frame_done_b), .line_err(line_err_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  int wr_addr_q[$];
  int wr_data_q[$];
  int done_cnt    = 0;
  int done_we_cnt = 0;
  int b_we_cnt    = 0;
  int b_last_addr = -1;
  int b_done_cnt  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Write log for the small instance, one line per memory write.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(int'(mem_data));
      $display("write addr=%0d data=0x%02h done=%0b", mem_addr, mem_data, frame_done);
    end
    if (frame_done) begin
      done_cnt++;
      if (mem_we) done_we_cnt++;
    end
  end

  // Tally for the larger instance.
  always @(negedge clk) begin
    if (mem_we_b) begin
      b_we_cnt++;
      b_last_addr = int'(mem_addr_b);
    end
    if (frame_done_b) b_done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt    = 0;
    done_we_cnt = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", int'(busy), 1);
  endtask

  // Present a pixel and hold it until the writer takes it.
  task automatic send_pixel(input logic [7:0] d, input logic eol);
    logic acc;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_eol   = eol;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = pix_ready;
      tick();
    end
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  // Feed one 4x2 frame of base..base+7; optional stall, bad eol, stray start.
  task automatic run_frame(input logic [7:0] base, input int stall_at,
                           input int bad_eol_at, input int start_at);
    for (int i = 0; i < 8; i++) begin
      if (i == start_at) begin
        pix_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_ignored_busy", int'(busy), 1);
        check("restart_no_we", int'(mem_we), 0);
      end
      if (i == stall_at) begin
        pix_valid = 1'b1;
        pix_data  = base + 8'(i);
        pix_eol   = ((i % 4) == 3);
        mem_busy  = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("stall_ready", int'(pix_ready), 0);
          tick();
          check("stall_we", int'(mem_we), 0);
        end
        mem_busy = 1'b0;
      end
      send_pixel(base + 8'(i), ((i % 4) == 3) ^ (i == bad_eol_at));
      if (i == bad_eol_at) check("line_err_set", int'(line_err), 1);
    end
    check("done_pulse", int'(frame_done), 1);
    check("done_we", int'(mem_we), 1);
    check("done_addr", int'(mem_addr), 7);
    check("done_data", int'(mem_data), int'(base) + 7);
    // pix_valid stays high through DONE: must not produce a write
    tick();
    pix_valid = 1'b0;
    check("after_done_pulse", int'(frame_done), 0);
    check("after_done_busy", int'(busy), 0);
    check("after_done_we", int'(mem_we), 0);
  endtask

  task automatic verify_frame(input logic [7:0] base, input int exp_err);
    check("wr_count", wr_addr_q.size(), 8);
    for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
      check($sformatf("wr_addr%0d", i), wr_addr_q[i], i);
      check($sformatf("wr_data%0d", i), wr_data_q[i], int'(base) + i);
    end
    check("done_count", done_cnt, 1);
    check("done_with_we", done_we_cnt, 1);
    check("line_err_end", int'(line_err), exp_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_eol = 1'b0;
    mem_busy = 1'b0; pix_data = 8'h00;
    reset_b = 1'b1; start_b = 1'b0; pix_valid_b = 1'b0; pix_eol_b = 1'b0;
    mem_busy_b = 1'b0; pix_data_b = 8'h00;
    repeat (3) tick();

    // Reset state
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(pix_ready), 0);
    check("rst_we", int'(mem_we), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_data", int'(mem_data), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_line_err", int'(line_err), 0);
    reset = 1'b0;
    reset_b = 1'b0;
    tick();

    // Scenario 1: clean frame
    clear_log();
    do_start();
    check("s1_ready", int'(pix_ready), 1);
    run_frame(8'h10, -1, -1, -1);
    verify_frame(8'h10, 0);

    // Scenario 2: memory held for 3 cycles at pixel 0x13
    clear_log();
    do_start();
    run_frame(8'h10, 3, -1, -1);
    verify_frame(8'h10, 0);

    // Scenario 3: early eol at x=2 of line 0
    clear_log();
    do_start();
    run_frame(8'h30, -1, 2, -1);
    verify_frame(8'h30, 1);
    tick();
    check("line_err_sticky_idle", int'(line_err), 1);

    // Scenario 5: pix_valid in IDLE is ignored, start in WRITE is ignored
    clear_log();
    pix_valid = 1'b1;
    pix_data  = 8'h55;
    repeat (4) tick();
    pix_valid = 1'b0;
    check("idle_no_write", wr_addr_q.size(), 0);
    check("idle_busy", int'(busy), 0);
    do_start();
    check("start_clears_line_err", int'(line_err), 0);
    run_frame(8'h40, -1, -1, 2);
    verify_frame(8'h40, 0);

    // Scenario 4: reset after 5 pixels aborts the frame
    clear_log();
    do_start();
    for (int i = 0; i < 5; i++) send_pixel(8'h20 + 8'(i), (i % 4) == 3);
    check("s4_fifth_we", int'(mem_we), 1);
    check("s4_fifth_addr", int'(mem_addr), 4);
    reset = 1'b1;
    start = 1'b1;
    tick();
    check("s4_rst_we", int'(mem_we), 0);
    check("s4_rst_busy", int'(busy), 0);
    check("s4_rst_done", int'(frame_done), 0);
    check("s4_rst_addr", int'(mem_addr), 0);
    check("s4_rst_data", int'(mem_data), 0);
    check("s4_rst_ready", int'(pix_ready), 0);
    // reset still wins over start from IDLE
    tick();
    check("s4_rst_prio_busy", int'(busy), 0);
    reset = 1'b0;
    start = 1'b0;
    pix_valid = 1'b0;
    repeat (3) tick();
    check("s4_no_done", done_cnt, 0);
    check("s4_writes_before_abort", wr_addr_q.size(), 5);
    clear_log();
    do_start();
    run_frame(8'h50, -1, -1, -1);
    verify_frame(8'h50, 0);

    // Scenario 6: complete 40x30 frame on the larger instance
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_busy", int'(busy_b), 1);
    pix_valid_b = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      pix_data_b = 8'(i);
      pix_eol_b  = ((i % 40) == 39);
      tick();
    end
    check("b_done_pulse", int'(frame_done_b), 1);
    pix_valid_b = 1'b0;
    tick();
    tick();
    check("b_we_count", b_we_cnt, 1200);
    check("b_last_addr", b_last_addr, 1199);
    check("b_done_count", b_done_cnt, 1);
    check("b_line_err", int'(line_err_b), 0);
    check("b_idle", int'(busy_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_buffer_writer.md
FRAME_BUFFER_WRITER -- requirements
Module: frame_buffer_writer

Interface
REQ-001 Parameter H_RES, default 640, pixels per line.
REQ-002 Parameter V_RES, default 480, lines per frame.
REQ-003 Parameter ADDR_W, default 19, memory address width; H_RES*V_RES SHALL be at most 2^ADDR_W.
REQ-004 clk  input  1  single clock; every register SHALL be clocked on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to begin capturing one frame.
REQ-007 pix_valid  input  1  pix_data is valid this cycle.
REQ-008 pix_data  input  8  grayscale pixel byte.
REQ-009 pix_eol  input  1  qualifies pix_data as the last pixel of a line.
REQ-010 mem_busy  input  1  frame memory is held by the display reader; no write is allowed this cycle.
REQ-011 pix_ready  output  1  writer accepts a pixel this cycle.
REQ-012 mem_addr  output  ADDR_W  frame memory byte address.
REQ-013 mem_data  output  8  byte to write.
REQ-014 mem_we  output  1  write strobe.
REQ-015 busy  output  1  a frame capture is in progress.
REQ-016 frame_done  output  1  one-cycle pulse when the frame completes.
REQ-017 line_err  output  1  sticky flag: pix_eol did not match the column count.

Function
REQ-018 A pixel is accepted when pix_valid and pix_ready are both 1 on the same rising edge.
REQ-019 The state machine SHALL have three states: IDLE, WRITE and DONE.
REQ-020 IDLE SHALL go to WRITE on start=1; on entry x, y and the linear address counter SHALL be 0 and line_err SHALL be cleared.
REQ-021 WRITE SHALL go to DONE on the accept that has x=H_RES-1 and y=V_RES-1.
REQ-022 DONE SHALL return to IDLE after exactly one cycle, asserting frame_done=1 for that cycle.
REQ-023 pix_ready SHALL be 1 only when the state is WRITE and mem_busy=0 (combinational from the state register and mem_busy).
REQ-024 On an accept, in the next cycle: mem_we=1, mem_data=pix_data, and mem_addr=the linear counter value before increment (latency 1).
REQ-025 mem_we SHALL be 0 in every cycle that does not follow an accept.
REQ-026 The linear address SHALL increment by 1 per accept and SHALL equal y*H_RES+x; no multiplier is used.
REQ-027 x SHALL wrap from H_RES-1 to 0 and increment y.
REQ-028 If pix_eol=1 at x≠H_RES-1, or pix_eol=0 at x=H_RES-1, line_err SHALL be set. Counters SHALL follow x only, never pix_eol.
REQ-029 start while in WRITE or DONE SHALL be ignored.
REQ-030 pix_valid while in IDLE or DONE SHALL be ignored; no memory write results.
REQ-031 While mem_busy=1, the held pixel is not consumed and the counters SHALL hold.
REQ-032 busy SHALL be 1 in WRITE and DONE and 0 in IDLE.
REQ-033 The final pixel's mem_we SHALL coincide with the frame_done cycle.

Reset
REQ-034 While reset=1 at a rising edge, the state SHALL become IDLE, and x, y, the address counter, mem_addr, mem_data, mem_we, frame_done and line_err SHALL be 0.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no frame_done and no further writes.
REQ-036 reset takes priority over start and pix_valid in the same cycle.

Structure
REQ-037 State encodings and the H_RES, V_RES and ADDR_W defaults SHALL live in the shared video constants package used by the display path.
REQ-038 The x/y/linear counter SHALL be one sub-module, pixel_addr_counter (inputs: clear and advance; outputs: x, y, addr, last).
REQ-039 The remainder SHALL be a single FSM together with the output registers.

Verification
REQ-040 Scenario 1: H_RES=4, V_RES=2; start, then 8 pixels 0x10..0x17 with a correct eol -> writes to addresses 0..7 with data 0x10..0x17, frame_done on the 8th write cycle, line_err=0.
REQ-041 Scenario 2: mem_busy=1 for 3 cycles mid-frame, with pix_valid held at pixel 0x13 -> pix_ready=0 and mem_we=0 for 3 cycles; 0x13 is then written once, to address 3.
REQ-042 Scenario 3: pix_eol on x=2 of line 0 -> line_err=1 and stays 1 to the end of the frame; addresses remain 0..7.
REQ-043 Scenario 4: reset asserted after 5 pixels -> mem_we=0 next cycle, busy=0, no frame_done; a new start then writes from address 0.
REQ-044 Scenario 5: start pulsed in WRITE, and pix_valid in IDLE -> no restart and no write.
REQ-045 Scenario 6: default parameters with a full 640x480 frame -> last address 307199 and exactly 307200 mem_we pulses.
